wakeup_tag_broadcaster: RTL

- Producer end of the issue-queue wakeup interface: takes destination physical tags of issued instructions with their execution latency and broadcasts each tag on its lane in the exact cycle the result becomes forwardable.
- Its outputs drive the tag inputs of the wakeup CAM, which compares them against stored source tags.
- One delay line per issue lane; exposes per-lane slot-occupancy so select logic can avoid same-cycle broadcast collisions.

---
 rtl/wakeup_tag_broadcaster_pkg.sv | 19 +
 rtl/wakeup_tag_broadcaster_lane_delay_line.sv | 76 +++++++
 rtl/wakeup_tag_broadcaster.sv | 55 +++++
 3 files changed

// File: rtl/wakeup_tag_broadcaster_pkg.sv
// Shared types for the issue-queue wakeup tag broadcaster.
// Stage entries, latency field and the empty-entry constant.
package wakeup_tag_broadcaster_pkg;

    localparam int DEF_ISSUE_W = 4;
    localparam int DEF_TAG_W   = 7;
    localparam int DEF_MAX_LAT = 4;
    localparam int DEF_LAT_W   = 3;

    typedef logic [DEF_LAT_W-1:0] lat_t;

    typedef struct packed {
        logic                 valid;
        logic [DEF_TAG_W-1:0] tag;
    } stage_t;

    localparam stage_t STAGE_EMPTY = '{valid: 1'b0, tag: '0};

endpackage

// File: rtl/wakeup_tag_broadcaster_lane_delay_line.sv
// One lane of the wakeup broadcaster: MAX_LAT-stage shift/insert line.
// Reports slot occupancy and flags illegal or colliding issues.
module wakeup_lane_delay_line
    import wakeup_tag_broadcaster_pkg::*;
#(
    parameter int MAX_LAT = DEF_MAX_LAT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 active,
    input  logic                 flush,
    input  logic                 issue_valid,
    input  logic [DEF_TAG_W-1:0] issue_tag,
    input  lat_t                 issue_lat,
    output logic                 bcast_valid,
    output logic [DEF_TAG_W-1:0] bcast_tag,
    output logic [MAX_LAT-1:0]   slot_busy,
    output logic                 collision
);

    stage_t s_q [MAX_LAT];
    stage_t s_d [MAX_LAT];
    logic   lat_ok;

    always_comb begin
        s_d[MAX_LAT-1] = STAGE_EMPTY;
        for (int k = 0; k < MAX_LAT-1; k++) begin
            s_d[k] = s_q[k+1];
        end
        collision = 1'b0;
        lat_ok = (issue_lat != '0) && (issue_lat <= lat_t'(MAX_LAT));
        if (issue_valid && active && !flush) begin
            if (!lat_ok) begin
                collision = 1'b1;
            end else begin
                // Target slot is checked after the shift: an occupant wins.
                for (int k = 0; k < MAX_LAT; k++) begin
                    if (lat_t'(k+1) == issue_lat) begin
                        if (s_d[k].valid) begin
                            collision = 1'b1;
                        end else begin
                            s_d[k] = '{valid: 1'b1, tag: issue_tag};
                        end
                    end
                end
            end
        end
        if (flush || !active) begin
            for (int k = 0; k < MAX_LAT; k++) begin
                s_d[k] = STAGE_EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_q <= '{default: STAGE_EMPTY};
        end else begin
            s_q <= s_d;
        end
    end

    always_comb begin
        slot_busy = '1;
        if (active) begin
            slot_busy[MAX_LAT-1] = 1'b0;
            for (int k = 0; k < MAX_LAT-1; k++) begin
                slot_busy[k] = s_q[k+1].valid;
            end
        end
    end

    assign bcast_valid = active && s_q[0].valid;
    assign bcast_tag   = bcast_valid ? s_q[0].tag : '0;

endmodule

// File: rtl/wakeup_tag_broadcaster.sv
// Wakeup tag broadcaster: per-lane delay lines feeding the wakeup CAM.
// Collisions from all lanes fold into one sticky error flag.
module wakeup_tag_broadcaster
    import wakeup_tag_broadcaster_pkg::*;
#(
    parameter int ISSUE_W = DEF_ISSUE_W,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int MAX_LAT = DEF_MAX_LAT,
    parameter int LAT_W   = DEF_LAT_W
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [ISSUE_W-1:0]              issueValid_i,
    input  logic [ISSUE_W-1:0][TAG_W-1:0]   issueTag_i,
    input  logic [ISSUE_W-1:0][LAT_W-1:0]   issueLat_i,
    input  logic [ISSUE_W-1:0]              laneActive_i,
    input  logic                            flush_i,
    output logic [ISSUE_W-1:0][MAX_LAT-1:0] slotBusy_o,
    output logic [ISSUE_W-1:0]              bcastValid_o,
    output logic [ISSUE_W-1:0][TAG_W-1:0]   bcastTag_o,
    output logic                            collision_o
);

    logic [ISSUE_W-1:0] lane_coll;
    logic               collision_q;

    for (genvar g = 0; g < ISSUE_W; g++) begin : g_lane
        wakeup_lane_delay_line #(
            .MAX_LAT (MAX_LAT)
        ) u_line (
            .clk         (clk),
            .reset       (reset),
            .active      (laneActive_i[g]),
            .flush       (flush_i),
            .issue_valid (issueValid_i[g]),
            .issue_tag   (issueTag_i[g]),
            .issue_lat   (issueLat_i[g]),
            .bcast_valid (bcastValid_o[g]),
            .bcast_tag   (bcastTag_o[g]),
            .slot_busy   (slotBusy_o[g]),
            .collision   (lane_coll[g])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            collision_q <= 1'b0;
        end else if (|lane_coll) begin
            collision_q <= 1'b1;
        end
    end

    assign collision_o = collision_q;

endmodule
